// File: rtl/vta_mem_pkg.sv
// Shared opcode constants and controller state encoding for the DPI memory arbiter.
package vta_mem_pkg;

  localparam logic OPC_RD = 1'b0;
  localparam logic OPC_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WRITE,
    READ
  } state_t;

endpackage

// File: rtl/vta_mem_rr_arb.sv
// Combinational round-robin picker: first valid channel at or after ptr, wrapping.
module vta_mem_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  index,
  output logic              any
);

  int               slot;
  logic [IDX_W-1:0] slot_idx;

  always_comb begin
    grant    = '0;
    index    = '0;
    any      = 1'b0;
    slot     = 0;
    slot_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      slot = int'(ptr) + k;
      if (slot >= NUM_CH) slot = slot - NUM_CH;
      slot_idx = IDX_W'(slot);
      if (!any && valid[slot_idx]) begin
        any             = 1'b1;
        index           = slot_idx;
        grant[slot_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vta_mem_dpi_arbiter.sv
// Round-robin front end multiplexing NUM_CH load/store clients onto one DPI memory port,
// holding the grant for a whole len+1 beat burst.
module vta_mem_dpi_arbiter
  import vta_mem_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int LEN_BITS  = 8,
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_req_valid,
  output logic [NUM_CH-1:0]           ch_req_ready,
  input  logic [NUM_CH-1:0]           ch_req_opcode,
  input  logic [NUM_CH*LEN_BITS-1:0]  ch_req_len,
  input  logic [NUM_CH*ADDR_BITS-1:0] ch_req_addr,
  input  logic [NUM_CH-1:0]           ch_wr_valid,
  output logic [NUM_CH-1:0]           ch_wr_ready,
  input  logic [NUM_CH*DATA_BITS-1:0] ch_wr_bits,
  output logic [NUM_CH-1:0]           ch_rd_valid,
  input  logic [NUM_CH-1:0]           ch_rd_ready,
  output logic [DATA_BITS-1:0]        ch_rd_bits,
  output logic                        dpi_req_valid,
  output logic                        dpi_req_opcode,
  output logic [LEN_BITS-1:0]         dpi_req_len,
  output logic [ADDR_BITS-1:0]        dpi_req_addr,
  output logic                        dpi_wr_valid,
  output logic [DATA_BITS-1:0]        dpi_wr_bits,
  input  logic                        dpi_rd_valid,
  input  logic [DATA_BITS-1:0]        dpi_rd_bits,
  output logic                        dpi_rd_ready
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    next_ptr;
  logic [LEN_BITS-1:0] count;
  logic [NUM_CH-1:0]   grant;
  logic [NUM_CH-1:0]   owner_oh;
  logic                grant_any;
  logic                beat;

  vta_mem_rr_arb #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .valid (ch_req_valid),
    .ptr   (ptr),
    .grant (grant),
    .index (grant_idx),
    .any   (grant_any)
  );

  assign owner_oh = NUM_CH'(1) << owner;
  assign next_ptr = (owner == IDX_W'(NUM_CH - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    beat = 1'b0;
    case (state)
      WRITE:   beat = ch_wr_valid[owner];
      READ:    beat = dpi_rd_valid & ch_rd_ready[owner];
      default: beat = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      owner          <= '0;
      count          <= '0;
      dpi_req_valid  <= 1'b0;
      dpi_req_opcode <= 1'b0;
      dpi_req_len    <= '0;
      dpi_req_addr   <= '0;
    end else begin
      dpi_req_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner          <= grant_idx;
            dpi_req_opcode <= ch_req_opcode[grant_idx];
            dpi_req_len    <= ch_req_len[grant_idx*LEN_BITS +: LEN_BITS];
            dpi_req_addr   <= ch_req_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
            count          <= ch_req_len[grant_idx*LEN_BITS +: LEN_BITS];
            dpi_req_valid  <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: state <= (dpi_req_opcode == OPC_WR) ? WRITE : READ;
        WRITE, READ: begin
          // count holds beats remaining minus one, so it stops at zero and never wraps.
          if (beat) begin
            if (count == '0) begin
              state <= IDLE;
              ptr   <= next_ptr;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the request grant is combinational, so it is gated by reset to read 0 while reset is held.
  always_comb begin
    ch_req_ready = '0;
    ch_wr_ready  = '0;
    ch_rd_valid  = '0;
    ch_rd_bits   = '0;
    dpi_wr_valid = 1'b0;
    dpi_wr_bits  = '0;
    dpi_rd_ready = 1'b0;
    case (state)
      IDLE: if (!reset) ch_req_ready = grant;
      WRITE: begin
        ch_wr_ready  = owner_oh;
        dpi_wr_valid = ch_wr_valid[owner];
        dpi_wr_bits  = ch_wr_bits[owner*DATA_BITS +: DATA_BITS];
      end
      READ: begin
        ch_rd_valid  = dpi_rd_valid ? owner_oh : '0;
        ch_rd_bits   = dpi_rd_bits;
        dpi_rd_ready = ch_rd_ready[owner];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vta_mem_dpi_arbiter.sv
// Table-driven burst bench for vta_mem_dpi_arbiter with a data scoreboard and reset corner case.
module tb_vta_mem_dpi_arbiter;

  localparam int NUM_CH    = 4;
  localparam int LEN_BITS  = 8;
  localparam int ADDR_BITS = 64;
  localparam int DATA_BITS = 64;

  logic                        clock;
  logic                        reset;
  logic [NUM_CH-1:0]           ch_req_valid;
  logic [NUM_CH-1:0]           ch_req_ready;
  logic [NUM_CH-1:0]           ch_req_opcode;
  logic [NUM_CH*LEN_BITS-1:0]  ch_req_len;
  logic [NUM_CH*ADDR_BITS-1:0] ch_req_addr;
  logic [NUM_CH-1:0]           ch_wr_valid;
  logic [NUM_CH-1:0]           ch_wr_ready;
  logic [NUM_CH*DATA_BITS-1:0] ch_wr_bits;
  logic [NUM_CH-1:0]           ch_rd_valid;
  logic [NUM_CH-1:0]           ch_rd_ready;
  logic [DATA_BITS-1:0]        ch_rd_bits;
  logic                        dpi_req_valid;
  logic                        dpi_req_opcode;
  logic [LEN_BITS-1:0]         dpi_req_len;
  logic [ADDR_BITS-1:0]        dpi_req_addr;
  logic                        dpi_wr_valid;
  logic [DATA_BITS-1:0]        dpi_wr_bits;
  logic                        dpi_rd_valid;
  logic [DATA_BITS-1:0]        dpi_rd_bits;
  logic                        dpi_rd_ready;

  vta_mem_dpi_arbiter #(
    .NUM_CH    (NUM_CH),
    .LEN_BITS  (LEN_BITS),
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ch_req_valid   (ch_req_valid),
    .ch_req_ready   (ch_req_ready),
    .ch_req_opcode  (ch_req_opcode),
    .ch_req_len     (ch_req_len),
    .ch_req_addr    (ch_req_addr),
    .ch_wr_valid    (ch_wr_valid),
    .ch_wr_ready    (ch_wr_ready),
    .ch_wr_bits     (ch_wr_bits),
    .ch_rd_valid    (ch_rd_valid),
    .ch_rd_ready    (ch_rd_ready),
    .ch_rd_bits     (ch_rd_bits),
    .dpi_req_valid  (dpi_req_valid),
    .dpi_req_opcode (dpi_req_opcode),
    .dpi_req_len    (dpi_req_len),
    .dpi_req_addr   (dpi_req_addr),
    .dpi_wr_valid   (dpi_wr_valid),
    .dpi_wr_bits    (dpi_wr_bits),
    .dpi_rd_valid   (dpi_rd_valid),
    .dpi_rd_bits    (dpi_rd_bits),
    .dpi_rd_ready   (dpi_rd_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One burst per record: channels added to the pending set, the channel expected to win,
  // whether it keeps requesting afterwards, and the burst shape plus read stall / write gap.
  typedef struct {
    logic [NUM_CH-1:0] mask_add;
    int                ch;
    int                keep;
    logic              op;
    int                len;
    logic [63:0]       addr;
    logic [63:0]       seed;
    logic [63:0]       step;
    int                stall_at;
    int                stall_n;
    int                gap_at;
  } vec_t;

  vec_t              vecs[10];
  logic [63:0]       sb[$];
  logic [NUM_CH-1:0] req_mask;
  int                n_checks;
  int                n_pass;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic serve(input vec_t v);
    logic [NUM_CH-1:0] oh;
    logic [63:0]       exp;
    logic              rdy;
    logic              wv;
    int                beat;
    int                cyc;
    int                pushed;
    oh = NUM_CH'(1) << v.ch;
    req_mask |= v.mask_add;
    ch_req_opcode[v.ch] = v.op;
    ch_req_len[v.ch*LEN_BITS +: LEN_BITS]    = v.len[LEN_BITS-1:0];
    ch_req_addr[v.ch*ADDR_BITS +: ADDR_BITS] = v.addr;

    @(negedge clock);
    ch_req_valid = req_mask;
    #1;
    check("grant", ch_req_ready, oh);
    if (v.keep == 0) req_mask[v.ch] = 1'b0;

    @(negedge clock);
    ch_req_valid = req_mask;
    #1;
    check("issue_valid", dpi_req_valid, 1);
    check("issue_opcode", dpi_req_opcode, v.op);
    check("issue_len", dpi_req_len, v.len[LEN_BITS-1:0]);
    check("issue_addr", dpi_req_addr, v.addr);
    check("issue_req_ready", ch_req_ready, 0);

    beat   = 0;
    cyc    = 0;
    pushed = 0;
    while (beat <= v.len && cyc < 600) begin
      @(negedge clock);
      if (v.op) begin
        wv = (cyc != v.gap_at);
        ch_wr_valid = '0;
        ch_wr_valid[v.ch] = wv;
        ch_wr_bits[v.ch*DATA_BITS +: DATA_BITS] = v.seed + v.step * beat;
        if (wv) sb.push_back(v.seed + v.step * beat);
        #1;
        check("wr_valid", dpi_wr_valid, wv);
        check("wr_ready", ch_wr_ready, oh);
        if (wv) begin
          exp = sb.pop_front();
          check("wr_bits", dpi_wr_bits, exp);
          beat++;
        end
      end else begin
        rdy = !(v.stall_n > 0 && cyc >= v.stall_at && cyc < v.stall_at + v.stall_n);
        dpi_rd_valid = 1'b1;
        dpi_rd_bits  = v.seed + v.step * beat;
        if (pushed == beat) begin
          sb.push_back(v.seed + v.step * beat);
          pushed++;
        end
        ch_rd_ready = '1;
        ch_rd_ready[v.ch] = rdy;
        #1;
        check("rd_valid", ch_rd_valid, oh);
        check("rd_ready", dpi_rd_ready, rdy);
        if (rdy) begin
          exp = sb.pop_front();
          check("rd_bits", ch_rd_bits, exp);
          beat++;
        end
      end
      if (cyc == 0) begin
        check("pulse_once", dpi_req_valid, 0);
        check("busy_req_ready", ch_req_ready, 0);
      end
      cyc++;
    end
    if (beat <= v.len) check("beat_budget", beat, v.len + 1);

    // One extra offered beat after the burst must be refused on both sides.
    @(negedge clock);
    ch_req_valid = '0;
    ch_wr_valid  = '0;
    ch_wr_valid[v.ch] = v.op;
    dpi_rd_valid = !v.op;
    ch_rd_ready  = '1;
    #1;
    check("end_wr_ready", ch_wr_ready, 0);
    check("end_wr_valid", dpi_wr_valid, 0);
    check("end_rd_valid", ch_rd_valid, 0);
    check("end_rd_ready", dpi_rd_ready, 0);
    ch_wr_valid  = '0;
    dpi_rd_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_req_ready"}, ch_req_ready, 0);
    check({name, "_wr_ready"}, ch_wr_ready, 0);
    check({name, "_rd_valid"}, ch_rd_valid, 0);
    check({name, "_rd_bits"}, ch_rd_bits, 0);
    check({name, "_dpi_req"}, {dpi_req_valid, dpi_req_opcode, dpi_req_len}, 0);
    check({name, "_dpi_addr"}, dpi_req_addr, 0);
    check({name, "_dpi_wr"}, {63'd0, dpi_wr_valid}, 0);
    check({name, "_dpi_wr_bits"}, dpi_wr_bits, 0);
    check({name, "_dpi_rd_ready"}, dpi_rd_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    n_checks = 0;
    n_pass   = 0;
    req_mask = '0;
    reset         = 1'b1;
    ch_req_valid  = '0;
    ch_req_opcode = '0;
    ch_req_len    = '0;
    ch_req_addr   = '0;
    ch_wr_valid   = '0;
    ch_wr_bits    = '0;
    ch_rd_ready   = '0;
    dpi_rd_valid  = 1'b0;
    dpi_rd_bits   = '0;

    //           mask     ch keep op    len  addr          seed          step   stall    gap
    vecs[0] = '{4'b0001, 0, 0, 1'b0, 3,   64'h1000,     64'hA0,       64'h1, -1, 0,   -1};
    vecs[1] = '{4'b1000, 3, 0, 1'b1, 0,   64'h3000,     64'h30,       64'h1, -1, 0,   -1};
    vecs[2] = '{4'b0111, 0, 1, 1'b0, 1,   64'h100,      64'hB0,       64'h1, -1, 0,   -1};
    vecs[3] = '{4'b0000, 1, 0, 1'b0, 0,   64'h200,      64'hB8,       64'h1, -1, 0,   -1};
    vecs[4] = '{4'b0000, 2, 0, 1'b1, 2,   64'h300,      64'hC0,       64'h3, -1, 0,   -1};
    vecs[5] = '{4'b0000, 0, 0, 1'b0, 0,   64'h400,      64'hE0,       64'h1, -1, 0,   -1};
    vecs[6] = '{4'b0010, 1, 0, 1'b1, 1,   64'h500,      64'h11,       64'h11, -1, 0,   1};
    vecs[7] = '{4'b0100, 2, 0, 1'b0, 5,   64'h600,      64'hF00,      64'h5,  2, 3,   -1};
    vecs[8] = '{4'b1000, 3, 0, 1'b1, 255, 64'hDEAD0000, 64'h5500,     64'h1, -1, 0,   -1};
    vecs[9] = '{4'b0001, 0, 0, 1'b0, 0,   64'hFFFF_FFF8, 64'h1234_5678, 64'h1, -1, 0, -1};

    @(negedge clock);
    ch_req_valid = '1;
    #1;
    check_all_zero("reset");
    @(negedge clock);
    ch_req_valid = '0;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) serve(vecs[i]);

    // Reset asserted in the middle of a read burst on ch2.
    ch_req_opcode[2] = 1'b0;
    ch_req_len[2*LEN_BITS +: LEN_BITS]    = 8'd3;
    ch_req_addr[2*ADDR_BITS +: ADDR_BITS] = 64'h2200;
    @(negedge clock);
    ch_req_valid = 4'b0100;
    #1;
    check("rst_grant", ch_req_ready, 4'b0100);
    @(negedge clock);
    ch_req_valid = '0;
    #1;
    check("rst_issue", dpi_req_valid, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      dpi_rd_valid = 1'b1;
      dpi_rd_bits  = 64'hC0 + 64'(i);
      ch_rd_ready  = '1;
      #1;
      check("rst_pre_rd_valid", ch_rd_valid, 4'b0100);
      check("rst_pre_rd_bits", ch_rd_bits, 64'hC0 + 64'(i));
    end
    @(negedge clock);
    reset        = 1'b1;
    ch_req_valid = '1;
    ch_wr_valid  = '1;
    #1;
    check_all_zero("midrst");
    @(negedge clock);
    #1;
    check("midrst_hold_req_ready", ch_req_ready, 0);
    reset        = 1'b0;
    ch_req_valid = '0;
    ch_wr_valid  = '0;
    dpi_rd_valid = 1'b0;
    sb.delete();

    rv = '{4'b1000, 3, 0, 1'b0, 0, 64'h3300, 64'hD0, 64'h1, -1, 0, -1};
    serve(rv);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
